re_shifter_pipe: RTL
====================

// Module: re_shifter_pipe
// PURPOSE
//  Pipelined, parametrised leading-one normaliser for the log-domain datapath: finds k = index of
//  the MS set bit of num, and m1 = the bits below that one, left-aligned, truncated to M1_WIDTH.
//  Generalises the 32-bit combinational shifter to any width, adds valid/ready flow control, a
//  zero flag and a sideband tag. Sits between operand capture and the log-add/remap stages.
// PARAMETERS
//  NUM_WIDTH  32                  input operand width (>=2)
//  K_WIDTH    $clog2(NUM_WIDTH)   width of k
//  M1_WIDTH   8                   mantissa width after the implicit leading one is dropped
//  TAG_WIDTH  4                   sideband tag carried alongside each beat (>=1)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-high
//  in_valid   in   1          input beat valid
//  in_ready   out  1          input beat accepted when in_valid && in_ready
//  in_num     in   NUM_WIDTH  operand
//  in_tag     in   TAG_WIDTH  sideband tag
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result when out_valid && out_ready
//  out_k      out  K_WIDTH    leading-one position
//  out_m1     out  M1_WIDTH   normalised mantissa, leading one removed
//  out_zero   out  1          operand was zero
//  out_tag    out  TAG_WIDTH  tag of this result
// BEHAVIOUR
//  - Two register stages. S1: capture num/tag, priority-encode k, zero flag. S2: left-shift num by
//    (NUM_WIDTH-1-k), take bits [NUM_WIDTH-2 -: M1_WIDTH] (zero-padded below bit 0) as m1.
//  - Latency exactly 2 cycles accept->out_valid with out_ready held high; throughput 1 beat/cycle.
//  - Flow control: S2 advances when !v2 || out_ready; S1 advances when !v1 || S2 advances;
//    in_ready = !v1 || (!v2 || out_ready) (combinational). No beat dropped, duplicated or reordered.
//  - out_* data held stable while out_valid && !out_ready.
//  - Zero operand: out_zero=1, out_k=0, out_m1=0.
//  - k < M1_WIDTH: missing low bits of m1 are 0. k=0: m1=0.
//  - Reset (any time, incl. mid-stream): v1=v2=0, out_valid=0, out_k=0, out_m1=0, out_zero=0,
//    out_tag=0; in-flight beats discarded; in_ready=1 in the first cycle after reset deasserts.
//  - No state machine beyond the two valid bits; all arithmetic unsigned.
// CONFIGURATION
//  RE_SHIFTER_ROUND_EN defined: m1 rounded to nearest (half-up) using the first bit below the
//    kept field (0 if it does not exist). Mantissa carry-out: m1=0, k=k+1. If k==NUM_WIDTH-1 and
//    carry-out occurs: saturate, m1=all ones, k unchanged. Latency unchanged (round in S2).
//  RE_SHIFTER_ROUND_EN undefined: plain truncation, no round/carry logic synthesised.
// TESTING (NUM_WIDTH=32, M1_WIDTH=8, out_ready=1 unless stated)
//  1. num=0x0000_0001 -> k=0, m1=0x00, zero=0, out_valid exactly 2 cycles after accept.
//  2. num=0x8000_0000 -> k=31, m1=0x00; num=0x0000_0B40 -> k=11, m1=0x68; num=0 -> zero=1,k=0,m1=0.
//  3. num=0x0000_03FF -> truncate: k=9, m1=0xFF; with RE_SHIFTER_ROUND_EN: k=10, m1=0x00;
//     num=0xFFFF_FFFF with ROUND_EN -> k=31, m1=0xFF (saturate).
//  4. Backpressure: out_ready=0, offer 3 beats tags 1,2,3 -> 2 accepted, in_ready=0 until
//     out_ready=1; then tags emerge 1,2,3 in order, data stable while stalled.
//  5. Streaming 1000 random beats with random in_valid/out_ready -> scoreboard matches golden model.
//  6. Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, no stale beat emitted.

Source files
------------

// File: rtl/re_shifter_pipe.sv
// rtl/re_shifter_pipe.sv - two-stage leading-one normaliser (k, m1, zero flag, tag) with valid/ready flow control
// Optional RE_SHIFTER_ROUND_EN: round m1 to nearest (half-up) with carry into k and saturation at the top.
module re_shifter_pipe #(
    parameter int NUM_WIDTH = 32,
    parameter int K_WIDTH   = $clog2(NUM_WIDTH),
    parameter int M1_WIDTH  = 8,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_WIDTH-1:0] in_num,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K_WIDTH-1:0]   out_k,
    output logic [M1_WIDTH-1:0]  out_m1,
    output logic                 out_zero,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam logic [K_WIDTH-1:0] K_MAX = K_WIDTH'(NUM_WIDTH - 1);

    logic                 v1;
    logic                 v2;
    logic [NUM_WIDTH-1:0] num1;
    logic [TAG_WIDTH-1:0] tag1;
    logic [K_WIDTH-1:0]   k1;
    logic                 zero1;

    logic                 s1_adv;
    logic                 s2_adv;
    logic [K_WIDTH-1:0]   enc_k;
    logic [K_WIDTH-1:0]   shamt;
    logic [K_WIDTH-1:0]   k_next;
    logic [M1_WIDTH-1:0]  m1_next;

    assign s2_adv    = !v2 || out_ready;
    assign s1_adv    = !v1 || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = v2;

    // Highest set bit wins: later iterations overwrite lower indices.
    always_comb begin
        enc_k = '0;
        for (int i = 0; i < NUM_WIDTH; i++) begin
            if (in_num[i]) begin
                enc_k = K_WIDTH'(i);
            end
        end
    end

    assign shamt = K_MAX - k1;

`ifdef RE_SHIFTER_ROUND_EN
    logic [M1_WIDTH:0] tail;
    logic [M1_WIDTH:0] m1_sum;

    // Zero padding below num1 lets the field and its round bit run past bit 0.
    always_comb begin
        tail   = (M1_WIDTH+1)'(({num1, {(M1_WIDTH+1){1'b0}}} << shamt) >> (NUM_WIDTH - 1));
        m1_sum = {1'b0, tail[M1_WIDTH:1]} + (M1_WIDTH+1)'(tail[0]);
        k_next  = k1;
        m1_next = m1_sum[M1_WIDTH-1:0];
        if (m1_sum[M1_WIDTH]) begin
            if (k1 == K_MAX) begin
                m1_next = '1;
            end else begin
                k_next = k1 + 1'b1;
            end
        end
    end
`else
    always_comb begin
        k_next  = k1;
        m1_next = M1_WIDTH'(({num1, {M1_WIDTH{1'b0}}} << shamt) >> (NUM_WIDTH - 1));
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            num1     <= '0;
            tag1     <= '0;
            k1       <= '0;
            zero1    <= 1'b0;
            out_k    <= '0;
            out_m1   <= '0;
            out_zero <= 1'b0;
            out_tag  <= '0;
        end else begin
            if (s1_adv) begin
                v1 <= in_valid;
                if (in_valid) begin
                    num1  <= in_num;
                    tag1  <= in_tag;
                    k1    <= enc_k;
                    zero1 <= ~|in_num;
                end
            end
            // Output data only changes when a new beat moves in, so it stays put under stall.
            if (s2_adv) begin
                v2 <= v1;
                if (v1) begin
                    out_k    <= k_next;
                    out_m1   <= m1_next;
                    out_zero <= zero1;
                    out_tag  <= tag1;
                end
            end
        end
    end

endmodule
